// File: rtl/clk_div_cfg_ctrl.sv
// Configuration owner for the 8-bit clock divider: round-robin arbitration of ratio-change
// requests and the gate -> load -> re-enable -> settle -> done sequence for each change.
module clk_div_cfg_ctrl #(
  parameter int          NUM_REQ   = 2,
  parameter int          GATE_CYC  = 2,
  parameter logic [7:0]  RST_RATIO = 8'd2
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [8*NUM_REQ-1:0]   i_ratio,
  output logic [NUM_REQ-1:0]     o_done,
  output logic                   o_busy,
  output logic [1:0]             o_owner,
  output logic [7:0]             o_div_ratio,
  output logic                   o_clk_en,
  output logic                   o_bypass,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATE   = 3'd1,
    LOAD   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Handshake: i_req[k] is a level held by requester k until o_done[k] pulses; the
  // request and its ratio are sampled only when IDLE picks k as owner.

  state_t               state_q;
  logic [1:0]           owner_q;
  logic [1:0]           rr_q;
  logic [7:0]           ratio_q;
  logic [8:0]           cnt_q;
  logic [7:0]           div_ratio_q;
  logic                 clk_en_q;
  logic                 bypass_q;
  logic                 busy_q;
  logic [NUM_REQ-1:0]   done_q;

  logic                 pick_valid;
  int                   pick_i;
  logic [7:0]           pick_ratio;

  // Scan from the highest offset down so the first requester at or after rr_q wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_i     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (i_req[idx]) begin
        pick_valid = 1'b1;
        pick_i     = idx;
      end
    end
    pick_ratio = i_ratio[8*pick_i +: 8];
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      rr_q        <= 2'd0;
      ratio_q     <= RST_RATIO;
      cnt_q       <= 9'd0;
      div_ratio_q <= RST_RATIO;
      clk_en_q    <= (RST_RATIO >= 8'd2);
      bypass_q    <= (RST_RATIO < 8'd2);
      busy_q      <= 1'b0;
      done_q      <= '0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= 2'(pick_i);
            ratio_q <= pick_ratio;
            busy_q  <= 1'b1;
            if (pick_ratio == div_ratio_q) begin
              state_q <= DONE;
              done_q  <= NUM_REQ'(1) << pick_i;
            end else begin
              state_q  <= GATE;
              clk_en_q <= 1'b0;
              cnt_q    <= 9'(GATE_CYC - 1);
            end
          end
        end
        GATE: begin
          if (cnt_q == 9'd0) begin
            // New ratio and enable reach the divider together as LOAD begins.
            state_q     <= LOAD;
            div_ratio_q <= ratio_q;
            bypass_q    <= (ratio_q < 8'd2);
            clk_en_q    <= (ratio_q >= 8'd2);
          end else begin
            cnt_q <= cnt_q - 9'd1;
          end
        end
        LOAD: begin
          if (ratio_q >= 8'd2) begin
            state_q <= SETTLE;
            cnt_q   <= {ratio_q, 1'b0} - 9'd1;
          end else begin
            state_q <= DONE;
            done_q  <= NUM_REQ'(1) << owner_q;
          end
        end
        SETTLE: begin
          if (cnt_q == 9'd0) begin
            state_q <= DONE;
            done_q  <= NUM_REQ'(1) << owner_q;
          end else begin
            cnt_q <= cnt_q - 9'd1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          rr_q    <= (int'(owner_q) + 1 >= NUM_REQ) ? 2'd0 : owner_q + 2'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_done      = done_q;
  assign o_busy      = busy_q;
  assign o_owner     = owner_q;
  assign o_div_ratio = div_ratio_q;
  assign o_clk_en    = clk_en_q;
  assign o_bypass    = bypass_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Directed bench for clk_div_cfg_ctrl: latency, gating, round-robin order, bypass and reset abort.
module tb_clk_div_cfg_ctrl;

  localparam int NUM_REQ = 2;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] ratio;
  logic [NUM_REQ-1:0]   o_done;
  logic                 o_busy;
  logic [1:0]           o_owner;
  logic [7:0]           o_div_ratio;
  logic                 o_clk_en;
  logic                 o_bypass;
  logic [2:0]           o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc;
  int en_low;
  int done_cnt;
  logic [7:0] load_ratio;
  logic [9:0] exp_q[$];

  clk_div_cfg_ctrl #(.NUM_REQ(NUM_REQ), .GATE_CYC(2), .RST_RATIO(8'd2)) dut (
    .i_ref_clk   (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_ratio     (ratio),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_owner     (o_owner),
    .o_div_ratio (o_div_ratio),
    .o_clk_en    (o_clk_en),
    .o_bypass    (o_bypass),
    .o_dbg_state (o_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input int k, input logic [7:0] r);
    req[k]          = 1'b1;
    ratio[8*k +: 8] = r;
    exp_q.push_back({2'(k), r});
  endtask

  // Counts edges from the one that first sees the request until o_done is visible.
  task automatic wait_done(input string tag, input int budget);
    logic got;
    got        = 1'b0;
    cyc        = 0;
    en_low     = 0;
    load_ratio = 8'd0;
    while (!got && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      if (!o_clk_en) en_low++;
      if (cyc == 3) load_ratio = o_div_ratio;
      if (o_done != '0) got = 1'b1;
    end
    check({tag, "_seen"}, 16'(got), 16'd1);
  endtask

  task automatic score(input string tag);
    logic [9:0] e;
    check({tag, "_sb_nonempty"}, 16'(exp_q.size() > 0), 16'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_done_vec"}, 16'(o_done), 16'(2'b01 << e[9:8]));
      check({tag, "_owner"}, 16'(o_owner), 16'(e[9:8]));
      check({tag, "_ratio"}, 16'(o_div_ratio), 16'(e[7:0]));
      check({tag, "_busy"}, 16'(o_busy), 16'd1);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ratio"}, 16'(o_div_ratio), 16'd2);
    check({tag, "_en"}, 16'(o_clk_en), 16'd1);
    check({tag, "_bypass"}, 16'(o_bypass), 16'd0);
    check({tag, "_busy"}, 16'(o_busy), 16'd0);
    check({tag, "_done"}, 16'(o_done), 16'd0);
  endtask

  initial begin
    rst   = 1'b1;
    req   = '0;
    ratio = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: defaults held.
    repeat (5) @(negedge clk);
    check_reset_vals("rst_idle");
    check("rst_owner", 16'(o_owner), 16'd0);

    // req0 ratio 4: gate 2 cycles, load at cycle 3, done 12 cycles after the request edge.
    drive(0, 8'd4);
    wait_done("r0_4", 600);
    check("r0_4_lat", 16'(cyc), 16'd12);
    check("r0_4_enlow", 16'(en_low), 16'd2);
    check("r0_4_load", 16'(load_ratio), 16'd4);
    score("r0_4");
    req[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("r0_4_idle_busy", 16'(o_busy), 16'd0);
    check("r0_4_idle_en", 16'(o_clk_en), 16'd1);

    // req1 with unchanged ratio: fast path, no gating.
    drive(1, 8'd4);
    wait_done("fast", 600);
    check("fast_lat", 16'(cyc), 16'd1);
    check("fast_enlow", 16'(en_low), 16'd0);
    score("fast");
    req[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous req0=6, req1=3; req0 re-requests (ratio 5) at its done so RR serves 1 next.
    drive(0, 8'd6);
    drive(1, 8'd3);
    wait_done("rr_a", 600);
    check("rr_a_lat", 16'(cyc), 16'd16);
    check("rr_a_enlow", 16'(en_low), 16'd2);
    score("rr_a");
    drive(0, 8'd5);
    wait_done("rr_b", 600);
    check("rr_b_lat", 16'(cyc), 16'd11);
    score("rr_b");
    req[1] = 1'b0;
    wait_done("rr_c", 600);
    check("rr_c_lat", 16'(cyc), 16'd15);
    score("rr_c");
    req[0] = 1'b0;
    repeat (2) @(negedge clk);

    // req0 ratio 1: bypass, enable never returns, done right after LOAD.
    drive(0, 8'd1);
    wait_done("byp", 600);
    check("byp_lat", 16'(cyc), 16'd4);
    check("byp_enlow", 16'(en_low), 16'd4);
    score("byp");
    check("byp_flag", 16'(o_bypass), 16'd1);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("byp_idle_en", 16'(o_clk_en), 16'd0);
    check("byp_idle_bypass", 16'(o_bypass), 16'd1);

    // req0 ratio 8 aborted by reset during SETTLE: no done, reset values return at once.
    req[0]       = 1'b1;
    ratio[7:0]   = 8'd8;
    repeat (6) @(posedge clk);
    #1;
    check("abort_in_settle", 16'(o_dbg_state), 16'd3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("abort_rst");
    req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (o_done != '0) done_cnt++;
    end
    check("abort_no_done", 16'(done_cnt), 16'd0);
    check_reset_vals("abort_idle");

    // A fresh request after the abort is served normally from the reset ratio.
    drive(1, 8'd3);
    wait_done("post", 600);
    check("post_lat", 16'(cyc), 16'd10);
    score("post");
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
